// File: rtl/vx_commit_pkg.sv
// Shared commit definitions: payload struct, source indices, thread popcount.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package vx_commit_pkg;

    localparam int UUID_BITS   = 44;
    localparam int NUM_WARPS   = 4;
    localparam int NW_BITS     = 2;
    localparam int NUM_THREADS = 4;
    localparam int NR_BITS     = 5;

    // Commit source order as seen on the arbiter request vector
    localparam int SRC_ALU  = 0;
    localparam int SRC_LSU  = 1;
    localparam int SRC_CSR  = 2;
    localparam int NUM_SRCS = 3;

    localparam int POP_W = $clog2(NUM_THREADS + 1);

    typedef struct packed {
        logic [UUID_BITS-1:0]      uuid;
        logic [NW_BITS-1:0]        wid;
        logic [NUM_THREADS-1:0]    tmask;
        logic [31:0]               pc;
        logic [NUM_THREADS*32-1:0] data;
        logic [NR_BITS-1:0]        rd;
        logic                      wb;
        logic                      eop;
    } commit_t;

    function automatic logic [POP_W-1:0] tmask_popcount(input logic [NUM_THREADS-1:0] m);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            c = c + POP_W'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the priority pointer.
// Latency: grant is combinational; pointer updates on the edge where advance is high.
// Backpressure: pointer only moves when the granted request is actually taken (advance).
module vx_rr_arbiter #(
    parameter int NUM_REQS = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant,
    output logic                grant_valid
);

    localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;

    // Pick the first request at or after ptr (wrapping); lower offsets overwrite higher ones
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQS;
            if (requests[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    // Priority moves to the source just after the winner, so every requester gets a turn
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= (grant_idx == PTR_W'(NUM_REQS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/vx_commit_writeback.sv
// Commit arbitration across ALU/LSU/CSR into a single registered writeback port; COMMIT_PERF_EN adds instret.
// Latency: 1 cycle from granted commit to wb_valid; commits with wb=0 retire without a writeback.
// Backpressure: wb=1 sources wait while the output is held (wb_valid && !wb_ready); wb_* stay stable.
module vx_commit_writeback
    import vx_commit_pkg::*;
#(
    parameter int NUM_REQS = 3,
    parameter int CNT_W    = 64
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic [NUM_REQS-1:0]                         commit_valid,
    input  logic [NUM_REQS-1:0][UUID_BITS-1:0]          commit_uuid,
    input  logic [NUM_REQS-1:0][NW_BITS-1:0]            commit_wid,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]        commit_tmask,
    input  logic [NUM_REQS-1:0][31:0]                   commit_PC,
    input  logic [NUM_REQS-1:0][NUM_THREADS*32-1:0]     commit_data,
    input  logic [NUM_REQS-1:0][NR_BITS-1:0]            commit_rd,
    input  logic [NUM_REQS-1:0]                         commit_wb,
    input  logic [NUM_REQS-1:0]                         commit_eop,
    output logic [NUM_REQS-1:0]                         commit_ready,
    output logic                                        wb_valid,
    output logic [UUID_BITS-1:0]                        wb_uuid,
    output logic [NW_BITS-1:0]                          wb_wid,
    output logic [NUM_THREADS-1:0]                      wb_tmask,
    output logic [31:0]                                 wb_PC,
    output logic [NR_BITS-1:0]                          wb_rd,
    output logic [NUM_THREADS*32-1:0]                   wb_data,
    output logic                                        wb_eop,
    input  logic                                        wb_ready,
    output logic [CNT_W-1:0]                            instret
);

    commit_t             req [NUM_REQS];
    commit_t             sel;
    logic                can_load;
    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] grant;
    logic                grant_valid;

    // Bundle per-source payloads and qualify requests: wb=1 sources need a free output slot
    always_comb begin
        can_load = !wb_valid || wb_ready;
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req[i] = '{uuid:  commit_uuid[i],  wid:  commit_wid[i], tmask: commit_tmask[i],
                       pc:    commit_PC[i],    data: commit_data[i], rd:   commit_rd[i],
                       wb:    commit_wb[i],    eop:  commit_eop[i]};
            eligible[i] = commit_valid[i] && (!commit_wb[i] || can_load);
        end
    end

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .requests    (eligible),
        .advance     (grant_valid),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Grant is one-hot, so selecting the winner's payload is a plain priority-free mux
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                sel = req[i];
            end
        end
    end

    assign commit_ready = grant & {NUM_REQS{reset_n}};

    // Output register: load on a wb=1 grant, otherwise drain when the sink accepts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_uuid  <= '0;
            wb_wid   <= '0;
            wb_tmask <= '0;
            wb_PC    <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_eop   <= 1'b0;
        end else if (grant_valid && sel.wb) begin
            wb_valid <= 1'b1;
            wb_uuid  <= sel.uuid;
            wb_wid   <= sel.wid;
            wb_tmask <= sel.tmask;
            wb_PC    <= sel.pc;
            wb_rd    <= sel.rd;
            wb_data  <= sel.data;
            wb_eop   <= sel.eop;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

`ifdef COMMIT_PERF_EN
    logic [CNT_W-1:0] instret_q;

    // Count active threads of every retiring instruction (last packet only), wrapping naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else if (grant_valid && sel.eop) begin
            instret_q <= instret_q + CNT_W'(tmask_popcount(sel.tmask));
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_vx_commit_writeback.sv
module tb_vx_commit_writeback;
    import vx_commit_pkg::*;

    localparam int NREQ = 3;
    localparam int CW   = 5;
`ifdef COMMIT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                                    clk;
    logic                                    reset_n;
    logic [NREQ-1:0]                         commit_valid;
    logic [NREQ-1:0][UUID_BITS-1:0]          commit_uuid;
    logic [NREQ-1:0][NW_BITS-1:0]            commit_wid;
    logic [NREQ-1:0][NUM_THREADS-1:0]        commit_tmask;
    logic [NREQ-1:0][31:0]                   commit_PC;
    logic [NREQ-1:0][NUM_THREADS*32-1:0]     commit_data;
    logic [NREQ-1:0][NR_BITS-1:0]            commit_rd;
    logic [NREQ-1:0]                         commit_wb;
    logic [NREQ-1:0]                         commit_eop;
    logic [NREQ-1:0]                         commit_ready;
    logic                                    wb_valid;
    logic [UUID_BITS-1:0]                    wb_uuid;
    logic [NW_BITS-1:0]                      wb_wid;
    logic [NUM_THREADS-1:0]                  wb_tmask;
    logic [31:0]                             wb_PC;
    logic [NR_BITS-1:0]                      wb_rd;
    logic [NUM_THREADS*32-1:0]               wb_data;
    logic                                    wb_eop;
    logic                                    wb_ready;
    logic [CW-1:0]                           instret;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] model;

    vx_commit_writeback #(.NUM_REQS(NREQ), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .commit_valid(commit_valid), .commit_uuid(commit_uuid), .commit_wid(commit_wid),
        .commit_tmask(commit_tmask), .commit_PC(commit_PC), .commit_data(commit_data),
        .commit_rd(commit_rd), .commit_wb(commit_wb), .commit_eop(commit_eop),
        .commit_ready(commit_ready),
        .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
        .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
        .wb_ready(wb_ready), .instret(instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic wb, input logic eop,
                           input logic [3:0] tm, input logic [4:0] rd, input logic [127:0] data);
        commit_valid[i] = v;
        commit_wb[i]    = wb;
        commit_eop[i]   = eop;
        commit_tmask[i] = tm;
        commit_rd[i]    = rd;
        commit_data[i]  = data;
        commit_uuid[i]  = UUID_BITS'(100 + i);
        commit_wid[i]   = NW_BITS'(i);
        commit_PC[i]    = 32'h1000 + 32'(i * 4);
    endtask

    function automatic logic [CW-1:0] exp_ir(input logic [CW-1:0] m);
        return PERF ? m : '0;
    endfunction

    initial begin
        int exp_src;
        int prev;
        logic [2:0] exp_g;

        model    = '0;
        reset_n  = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, 1'b1, 1'b1, 4'hF, 5'd1, 128'h0);

        // Reset state: ready gated off even with requests present
        #2;
        check("rst_ready", 128'(commit_ready), 128'(3'b000));
        check("rst_wb_valid", 128'(wb_valid), 128'(1'b0));
        check("rst_instret", 128'(instret), 128'(5'd0));
        check("rst_wb_data", wb_data, 128'h0);

        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_src(i, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 128'h0);

        // Single ALU commit, wb=1
        set_src(SRC_ALU, 1'b1, 1'b1, 1'b1, 4'b1111, 5'd5, 128'hA5A5A5A5);
        #1;
        check("alu_ready", 128'(commit_ready), 128'(3'b001));
        model = model + 5'd4;
        @(posedge clk); #1;
        set_src(SRC_ALU, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 128'h0);
        #1;
        check("alu_wb_valid", 128'(wb_valid), 128'(1'b1));
        check("alu_wb_rd", 128'(wb_rd), 128'(5'd5));
        check("alu_wb_data", wb_data, 128'hA5A5A5A5);
        check("alu_wb_tmask", 128'(wb_tmask), 128'(4'b1111));
        check("alu_wb_pc", 128'(wb_PC), 128'(32'h1000));
        check("alu_wb_uuid", 128'(wb_uuid), 128'(100));
        check("alu_wb_eop", 128'(wb_eop), 128'(1'b1));
        check("alu_instret", 128'(instret), 128'(exp_ir(5'd4)));
        check("alu_idle_ready", 128'(commit_ready), 128'(3'b000));
        @(posedge clk); #1;
        check("alu_drain", 128'(wb_valid), 128'(1'b0));

        // All sources, wb=1, sink always ready; pointer sits at 1 after the ALU grant
        for (int i = 0; i < NREQ; i++)
            set_src(i, 1'b1, 1'b1, 1'b1, 4'((1 << (i + 1)) - 1), 5'(10 + i), 128'(32'hD0 + i));
        exp_src = 1;
        prev    = -1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_g = 3'(1 << exp_src);
            check("rr_grant", 128'(commit_ready), 128'(exp_g));
            check("rr_instret", 128'(instret), 128'(exp_ir(model)));
            if (k > 0) begin
                check("rr_wb_valid", 128'(wb_valid), 128'(1'b1));
                check("rr_wb_rd", 128'(wb_rd), 128'(10 + prev));
            end
            model   = model + 5'(exp_src + 1);
            prev    = exp_src;
            exp_src = (exp_src + 1) % NREQ;
            @(posedge clk); #1;
        end

        // Output full and stalled: wb=0 source passes, wb=1 source waits
        set_src(SRC_ALU, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 128'h0);
        set_src(SRC_LSU, 1'b1, 1'b1, 1'b0, 4'b0011, 5'd11, 128'hD1);
        set_src(SRC_CSR, 1'b1, 1'b0, 1'b1, 4'b0101, 5'd12, 128'hD2);
        wb_ready = 1'b0;
        #1;
        check("stall_held_rd", 128'(wb_rd), 128'(5'd10));
        check("stall_csr_grant", 128'(commit_ready), 128'(3'b100));
        check("stall_instret0", 128'(instret), 128'(exp_ir(model)));
        model = model + 5'd2;
        @(posedge clk); #1;
        set_src(SRC_CSR, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 128'h0);
        #1;
        for (int c = 0; c < 4; c++) begin
            check("stall_ready", 128'(commit_ready), 128'(3'b000));
            check("stall_wb_valid", 128'(wb_valid), 128'(1'b1));
            check("stall_wb_rd", 128'(wb_rd), 128'(5'd10));
            check("stall_wb_data", wb_data, 128'hD0);
            check("stall_instret", 128'(instret), 128'(exp_ir(model)));
            @(posedge clk); #2;
        end
        wb_ready = 1'b1;
        #1;
        check("unstall_lsu_grant", 128'(commit_ready), 128'(3'b010));
        @(posedge clk); #1;
        set_src(SRC_LSU, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 128'h0);
        #1;
        check("unstall_wb_valid", 128'(wb_valid), 128'(1'b1));
        check("unstall_wb_rd", 128'(wb_rd), 128'(5'd11));
        check("unstall_wb_data", wb_data, 128'hD1);
        @(posedge clk); #2;
        check("unstall_drain", 128'(wb_valid), 128'(1'b0));

        // wb=0 commit: consumed without writeback, instret +2
        set_src(SRC_CSR, 1'b1, 1'b0, 1'b1, 4'b0101, 5'd7, 128'h77);
        #1;
        check("nowb_grant", 128'(commit_ready), 128'(3'b100));
        model = model + 5'd2;
        @(posedge clk); #1;
        set_src(SRC_CSR, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 128'h0);
        #1;
        check("nowb_wb_valid", 128'(wb_valid), 128'(1'b0));
        check("nowb_instret", 128'(instret), 128'(exp_ir(5'd20)));

        // Counter wrap: 20 + 4*4 = 36 -> 4 in a 5-bit counter
        set_src(SRC_ALU, 1'b1, 1'b0, 1'b1, 4'hF, 5'd0, 128'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("wrap_grant", 128'(commit_ready), 128'(3'b001));
            model = model + 5'd4;
            @(posedge clk); #1;
            check("wrap_instret", 128'(instret), 128'(exp_ir(model)));
        end
        check("wrap_final", 128'(instret), 128'(exp_ir(5'd4)));
        set_src(SRC_ALU, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 128'h0);

        // Asynchronous reset while holding a writeback
        set_src(SRC_LSU, 1'b1, 1'b1, 1'b1, 4'b0011, 5'd11, 128'hD1);
        wb_ready = 1'b0;
        @(posedge clk); #1;
        set_src(SRC_LSU, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 128'h0);
        #1;
        check("pre_rst_wb_valid", 128'(wb_valid), 128'(1'b1));
        #2;
        reset_n  = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < NREQ; i++)
            set_src(i, 1'b1, 1'b1, 1'b0, 4'hF, 5'(10 + i), 128'(32'hD0 + i));
        model = '0;
        #1;
        check("arst_wb_valid", 128'(wb_valid), 128'(1'b0));
        check("arst_wb_rd", 128'(wb_rd), 128'(5'd0));
        check("arst_wb_data", wb_data, 128'h0);
        check("arst_instret", 128'(instret), 128'(5'd0));
        check("arst_ready", 128'(commit_ready), 128'(3'b000));
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check("post_rst_grant0", 128'(commit_ready), 128'(3'b001));
        @(posedge clk); #2;
        check("post_rst_grant1", 128'(commit_ready), 128'(3'b010));
        check("post_rst_wb_valid", 128'(wb_valid), 128'(1'b1));
        check("post_rst_wb_rd", 128'(wb_rd), 128'(5'd10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_commit_writeback.md
VX_COMMIT_WRITEBACK -- requirements
Module: VX_commit_writeback

Interface
REQ-001 SHALL have parameter NUM_REQS, default 3: number of commit sources (ALU, LSU, CSR order = index 0..2).
REQ-002 SHALL have parameter CNT_W, default 64: width of instret counter.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port commit_valid, input, NUM_REQS: per-source commit request.
REQ-006 SHALL have ports commit_uuid/wid/tmask/PC/data/rd/wb/eop, input, NUM_REQS x (`UUID_BITS/`NW_BITS/`NUM_THREADS/32/`NUM_THREADS*32/`NR_BITS/1/1): per-source commit payload.
REQ-007 SHALL have port commit_ready, output, NUM_REQS: per-source accept; transfer when valid&&ready.
REQ-008 SHALL have ports wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop, output, widths as commit payload: register-file writeback.
REQ-009 SHALL have port wb_ready, input, 1: writeback sink accept.
REQ-010 SHALL have port instret, output, CNT_W: committed-thread count.

Function
REQ-011 can_load SHALL equal !wb_valid || wb_ready.
REQ-012 Source i SHALL be eligible when commit_valid[i] && (!commit_wb[i] || can_load).
REQ-013 Exactly one eligible source SHALL be granted per cycle via round-robin; none if no eligible source.
REQ-014 Priority pointer SHALL reset to 0; after grant of i it SHALL become (i+1) mod NUM_REQS; unchanged with no grant.
REQ-015 commit_ready[i] SHALL be 1 only for the granted source, combinational from current state and inputs.
REQ-016 A granted commit with wb=1 SHALL appear on wb_* the next cycle (latency 1) with payload unchanged.
REQ-017 A granted commit with wb=0 SHALL be consumed without driving wb_valid.
REQ-018 wb_* SHALL hold stable while wb_valid && !wb_ready.
REQ-019 wb_valid SHALL clear after wb_valid && wb_ready unless a new wb=1 commit is granted that cycle (back-to-back full throughput).
REQ-020 Simultaneous requests from all sources SHALL each be granted within NUM_REQS cycles (no starvation).
REQ-021 A commit SHALL never be dropped or duplicated.

Reset
REQ-022 Assertion of reset_n=0 SHALL immediately clear wb_valid, wb_* payload, pointer and instret to 0, discarding any held writeback.
REQ-023 commit_ready SHALL be 0 while reset_n=0.
REQ-024 Deassertion SHALL be synchronized externally; first grant may occur on the first edge after release.

Configuration
REQ-025 Macro COMMIT_PERF_EN defined: instret SHALL increase by popcount(tmask) of each granted commit with eop=1 (wb irrelevant), wrapping modulo 2^CNT_W.
REQ-026 COMMIT_PERF_EN undefined: instret SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-027 Commit payload struct typedef and source-index constants SHALL live in shared package VX_commit_pkg.
REQ-028 Arbitration SHALL be a sub-module VX_rr_arbiter (NUM_REQS requests, grant one-hot, grant_valid, advance input).

Verification
REQ-029 Single ALU commit wb=1 rd=5 data=0xA5A5A5A5 tmask=4'b1111 eop=1 -> wb_valid next cycle with same rd/data; instret=4 (PERF on).
REQ-030 All 3 sources valid wb=1 continuously, wb_ready=1 -> grants 0,1,2,0,... one per cycle, wb_valid held high.
REQ-031 wb_ready=0 for 5 cycles with output full, source 1 wb=1 and source 2 wb=0 valid -> source 2 granted, source 1 stalled, wb_* stable; source 1 granted on first cycle wb_ready=1.
REQ-032 Commit wb=0 eop=1 tmask=4'b0101 -> no wb_valid, instret +2.
REQ-033 reset_n pulled low mid-cycle while wb_valid=1 -> wb_valid=0 and instret=0 without a clock edge; pointer restarts at 0.
REQ-034 instret preloaded near 2^CNT_W-1 via forced commits -> wraps to low value, no X.
